// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state type, widths and next-state helper for the instruction sequencer
package instr_sequencer_pkg;

  localparam int PC_WIDTH_DEF = 11;
  localparam int COUNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_I,
    FETCH_D,
    EXEC,
    SAVE,
    HALTED
  } seq_state_t;

  // halt_req is only honoured at the end of SAVE so an instruction is never cut short
  function automatic seq_state_t seq_next(seq_state_t s, logic run, logic halt_req,
                                          logic mem_ready);
    case (s)
      IDLE:    seq_next = run ? FETCH_I : IDLE;
      FETCH_I: seq_next = mem_ready ? FETCH_D : FETCH_I;
      FETCH_D: seq_next = EXEC;
      EXEC:    seq_next = SAVE;
      SAVE:    seq_next = halt_req ? HALTED : FETCH_I;
      HALTED:  seq_next = (run && !halt_req) ? FETCH_I : HALTED;
      default: seq_next = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_reg.sv
// rtl/instr_sequencer_pc_reg.sv - program counter with captured next-pc and jump mux
import instr_sequencer_pkg::*;

module pc_reg #(
  parameter int          PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned PC_RESET = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture,
  input  logic                update,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] next_pc;

  // next_pc is latched during EXEC but only becomes visible on pc when SAVE ends
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= PC_WIDTH'(PC_RESET);
      next_pc <= PC_WIDTH'(PC_RESET);
    end else begin
      if (capture) next_pc <= jump_en ? jump_addr : pc + PC_WIDTH'(1);
      if (update)  pc      <= next_pc;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - four-phase instruction sequencer with halt/resume and retired-instruction counter
import instr_sequencer_pkg::*;

module instr_sequencer #(
  parameter int          PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned PC_RESET = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   halt_req,
  input  logic                   mem_ready,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   fetch_instr,
  output logic                   fetch_data,
  output logic                   alu_out,
  output logic                   file_save,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  seq_state_t state;
  seq_state_t state_nxt;

  assign state_nxt = seq_next(state, run, halt_req, mem_ready);

  // Enables are decoded from the next state so each one is high exactly while its state is current
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_instr <= 1'b0;
      fetch_data  <= 1'b0;
      alu_out     <= 1'b0;
      file_save   <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      fetch_instr <= (state_nxt == FETCH_I);
      fetch_data  <= (state_nxt == FETCH_D);
      alu_out     <= (state_nxt == EXEC);
      file_save   <= (state_nxt == SAVE);
      busy        <= (state_nxt != IDLE) && (state_nxt != HALTED);
      if (state == SAVE && instr_count != '1)
        instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .PC_RESET (PC_RESET)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .capture   (state == EXEC),
    .update    (state == SAVE),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed and randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [10:0] jump_addr = '0;
  logic [10:0] pc;
  logic        fetch_instr, fetch_data, alu_out, file_save, busy;
  logic [15:0] instr_count;

  int compared = 0;
  int mismatched = 0;

  // Reference: mode 0 idle, 1 running (phase 0..3 of an instruction), 2 halted
  int          m_mode = 0;
  int          m_phase = 0;
  int unsigned m_pc = 0;
  int unsigned m_next = 0;
  int unsigned m_cnt = 0;

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .halt_req    (halt_req),
    .mem_ready   (mem_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc          (pc),
    .fetch_instr (fetch_instr),
    .fetch_data  (fetch_data),
    .alu_out     (alu_out),
    .file_save   (file_save),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (!reset) begin
      m_mode = 0; m_phase = 0; m_pc = 0; m_next = 0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (run && (m_mode == 0 || !halt_req)) begin
        m_mode = 1; m_phase = 0;
      end
    end else begin
      case (m_phase)
        0: if (mem_ready) m_phase = 1;
        1: m_phase = 2;
        2: begin
          m_next = jump_en ? int'(jump_addr) : (m_pc + 1) % 2048;
          m_phase = 3;
        end
        default: begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          m_pc = m_next;
          if (halt_req) m_mode = 2;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("fetch_instr", 32'(fetch_instr), 32'(m_mode == 1 && m_phase == 0));
    chk("fetch_data", 32'(fetch_data), 32'(m_mode == 1 && m_phase == 1));
    chk("alu_out", 32'(alu_out), 32'(m_mode == 1 && m_phase == 2));
    chk("file_save", 32'(file_save), 32'(m_mode == 1 && m_phase == 3));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_for(input int mode, input int phase, input string tag);
    int n = 0;
    while (!(m_mode == mode && m_phase == phase) && n < 40) begin
      cycle();
      n++;
    end
    compared++;
    assert (m_mode == mode && m_phase == phase) else begin
      mismatched++;
      $error("FAIL %s: wait timed out after %0d cycles, observed mode %0d expected mode %0d", tag, n, m_mode, mode);
    end
  endtask

  initial begin
    repeat (2) cycle();

    // Straight-line run: three instructions in 13 edges
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1;
    repeat (13) cycle();
    chk("count_after_three", 32'(instr_count), 32'd3);

    // Memory stall in FETCH_I
    wait_for(1, 0, "wait_fetch_i");
    mem_ready = 1'b0;
    repeat (3) cycle();
    chk("stall_pc_stable", 32'(pc), 32'd3);
    chk("stall_fetch_held", 32'(fetch_instr), 32'd1);
    mem_ready = 1'b1;
    repeat (4) cycle();
    chk("stall_retired", 32'(instr_count), 32'd4);

    // Jumps, including one to the top address followed by wrap
    wait_for(1, 2, "wait_exec_j1");
    jump_en = 1'b1; jump_addr = 11'h7F0;
    cycle();
    jump_en = 1'b0;
    cycle();
    chk("jump_7f0", 32'(pc), 32'h7F0);
    wait_for(1, 2, "wait_exec_j2");
    jump_en = 1'b1; jump_addr = 11'h7FF;
    cycle();
    jump_en = 1'b0;
    cycle();
    chk("jump_7ff", 32'(pc), 32'h7FF);
    wait_for(1, 2, "wait_exec_wrap");
    repeat (2) cycle();
    chk("pc_wrap", 32'(pc), 32'd0);

    // Halt raised in FETCH_D, then resume
    wait_for(1, 1, "wait_fetch_d");
    halt_req = 1'b1; run = 1'b0;
    repeat (3) cycle();
    chk("halted_busy", 32'(busy), 32'd0);
    chk("halted_pc", 32'(pc), 32'd1);
    repeat (2) cycle();
    halt_req = 1'b0; run = 1'b1;
    cycle();
    chk("resume_fetch", 32'(fetch_instr), 32'd1);
    chk("resume_pc", 32'(pc), 32'd1);

    // Reset in the middle of EXEC
    wait_for(1, 2, "wait_exec_rst");
    reset = 1'b0;
    cycle();
    reset = 1'b1; run = 1'b0;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Counter saturation from a preloaded value
    m_cnt = 32'hFFFD;
    force dut.instr_count = 16'hFFFD;
    cycle();
    release dut.instr_count;
    cycle();
    chk("preload", 32'(instr_count), 32'hFFFD);
    run = 1'b1; mem_ready = 1'b1;
    repeat (17) cycle();
    chk("saturated", 32'(instr_count), 32'hFFFF);

    // Randomized traffic against the reference
    repeat (800) begin
      reset     = ($urandom_range(0, 63) != 0);
      run       = 1'($urandom_range(0, 1));
      halt_req  = ($urandom_range(0, 5) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      jump_en   = ($urandom_range(0, 3) == 0);
      jump_addr = 11'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
